// File: rtl/fifo_axis_packetizer.sv
// FIFO read stage: drains FIFO words through a 2-entry skid buffer and emits
// them as AXI4-Stream beats grouped into fixed-length packets.
module fifo_axis_packetizer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACKET_LEN = 16
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst,
  input  logic                  i_en,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_rd_valid,
  input  logic                  i_fifo_empty,
  output logic [DATA_WIDTH-1:0] o_axis_tdata,
  output logic                  o_axis_tvalid,
  input  logic                  i_axis_tready,
  output logic                  o_axis_tlast,
  output logic                  o_axis_tuser,
  output logic                  o_pkt_done,
  output logic                  o_busy,
  output logic                  o_ovf_err
);

  localparam int unsigned CNT_W = $clog2(PACKET_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_LEN - 1);

  logic [1:0]            occ, occ_nxt;
  logic                  inflight;
  logic [CNT_W-1:0]      beat_cnt, beat_nxt;
  logic [DATA_WIDTH-1:0] head, head_nxt, tail, tail_nxt;
  logic                  pop, push, ovf_set;

  assign o_axis_tdata = head;

  // Read credit counts words already buffered plus the one still in flight.
  always_comb begin
    pop          = o_axis_tvalid & i_axis_tready;
    push         = i_fifo_rd_valid & ~i_s_rst;
    o_fifo_rd_en = i_en & ~i_fifo_empty & ~i_s_rst &
                   ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);
  end

  // Buffer update: head is the presented beat, tail the skid entry.
  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    ovf_set  = 1'b0;
    case (occ)
      2'd0: begin
        if (push) begin
          head_nxt = i_fifo_rd_data;
          occ_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_nxt = i_fifo_rd_data;
        end else if (push) begin
          tail_nxt = i_fifo_rd_data;
          occ_nxt  = 2'd2;
        end else if (pop) begin
          occ_nxt  = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_nxt = tail;
          if (push) tail_nxt = i_fifo_rd_data;
          else      occ_nxt  = 2'd1;
        end else if (push) begin
          ovf_set = 1'b1;
        end
      end
    endcase

    beat_nxt = beat_cnt;
    if (pop) beat_nxt = (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      occ           <= 2'd0;
      inflight      <= 1'b0;
      beat_cnt      <= '0;
      head          <= '0;
      tail          <= '0;
      o_axis_tvalid <= 1'b0;
      o_axis_tlast  <= 1'b0;
      o_axis_tuser  <= 1'b0;
      o_pkt_done    <= 1'b0;
      o_busy        <= 1'b0;
      o_ovf_err     <= 1'b0;
    end else begin
      occ           <= occ_nxt;
      inflight      <= o_fifo_rd_en;
      beat_cnt      <= beat_nxt;
      head          <= head_nxt;
      tail          <= tail_nxt;
      o_axis_tvalid <= (occ_nxt != 2'd0);
      o_axis_tlast  <= (occ_nxt != 2'd0) && (beat_nxt == LAST_CNT);
      o_axis_tuser  <= (occ_nxt != 2'd0) && (beat_nxt == '0);
      o_pkt_done    <= pop & o_axis_tlast;
      o_busy        <= (occ_nxt != 2'd0) | o_fifo_rd_en | (beat_nxt != '0);
      o_ovf_err     <= o_ovf_err | ovf_set;
    end
  end

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Bench for fifo_axis_packetizer: queue-based FIFO model, per-cycle vector
// table for the basic packet, scoreboard for the backpressure/gap/reset cases.
module tb_fifo_axis_packetizer;

  logic       clk = 1'b0;
  logic       s_rst = 1'b1;
  logic       en = 1'b0;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_valid = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] axis_tdata;
  logic       axis_tvalid;
  logic       axis_tready = 1'b0;
  logic       axis_tlast;
  logic       axis_tuser;
  logic       pkt_done;
  logic       busy;
  logic       ovf_err;

  fifo_axis_packetizer #(.DATA_WIDTH(8), .PACKET_LEN(16)) dut (
    .i_clk          (clk),
    .i_s_rst        (s_rst),
    .i_en           (en),
    .o_fifo_rd_en   (fifo_rd_en),
    .i_fifo_rd_data (fifo_rd_data),
    .i_fifo_rd_valid(fifo_rd_valid),
    .i_fifo_empty   (fifo_empty),
    .o_axis_tdata   (axis_tdata),
    .o_axis_tvalid  (axis_tvalid),
    .i_axis_tready  (axis_tready),
    .o_axis_tlast   (axis_tlast),
    .o_axis_tuser   (axis_tuser),
    .o_pkt_done     (pkt_done),
    .o_busy         (busy),
    .o_ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, rdy;
    logic       rd_en, tvalid;
    logic [7:0] tdata;
    logic       tlast, tuser, done, busy;
  } vec_t;

  vec_t       vt[21];
  logic [7:0] q[$];
  logic [7:0] expq[$];
  int         n_chk = 0, n_pass = 0, cyc = 0;
  int         n_beats = 0, n_tlast = 0, n_tuser = 0;
  bit         pend_v = 0, inj = 0, done_due = 0, ovf_exp = 0, hold_prev = 0;
  logic [7:0] pend_d = 8'h00, hold_data = 8'h00;
  logic [1:0] hold_flags = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic load(input int base, input int n);
    for (int k = 0; k < n; k++) q.push_back(8'(base + k));
  endtask

  // One clock: drive at negedge, sample #1 later, then model the FIFO read.
  task automatic step(input logic r, input logic e, input logic rdy);
    logic [7:0] w;
    @(negedge clk);
    fifo_rd_valid = pend_v | inj;
    fifo_rd_data  = inj ? 8'hEE : pend_d;
    s_rst         = r;
    en            = e;
    axis_tready   = rdy;
    fifo_empty    = (q.size() == 0);
    #1;
    if (r) begin
      q.delete();
      expq.delete();
      n_beats = 0; n_tlast = 0; n_tuser = 0;
      done_due = 0; ovf_exp = 0; hold_prev = 0;
    end else begin
      if (!axis_tvalid) chk("idle_flags", 32'({axis_tlast, axis_tuser}), 32'd0);
      if (hold_prev) begin
        chk("hold_valid", 32'(axis_tvalid), 32'd1);
        chk("hold_data", 32'(axis_tdata), 32'(hold_data));
        chk("hold_flags", 32'({axis_tlast, axis_tuser}), 32'(hold_flags));
      end
      chk("pkt_done", 32'(pkt_done), 32'(done_due));
      chk("ovf_err", 32'(ovf_err), 32'(ovf_exp));
      done_due = 0;
      if (axis_tvalid && axis_tready) begin
        if (expq.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else begin
          w = expq.pop_front();
          chk("tdata", 32'(axis_tdata), 32'(w));
        end
        chk("tuser", 32'(axis_tuser), 32'(n_beats % 16 == 0));
        chk("tlast", 32'(axis_tlast), 32'(n_beats % 16 == 15));
        done_due = (n_beats % 16 == 15);
        n_tlast += int'(axis_tlast);
        n_tuser += int'(axis_tuser);
        n_beats++;
      end
      hold_prev  = axis_tvalid & ~axis_tready;
      hold_data  = axis_tdata;
      hold_flags = {axis_tlast, axis_tuser};
    end
    pend_v = fifo_rd_en;
    if (fifo_rd_en) begin
      if (q.size() == 0) chk("rd_when_empty", 32'd1, 32'd0);
      else begin
        pend_d = q.pop_front();
        expq.push_back(pend_d);
      end
    end
    if (inj) ovf_exp = 1;
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_until(input int target, input bit toggle);
    int budget = 0;
    while (n_beats < target && budget < 300) begin
      step(1'b0, 1'b1, toggle ? logic'(budget % 2 == 0) : 1'b1);
      budget++;
    end
    chk("run_until_reached", 32'(n_beats), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd;

    // Basic 16-beat packet, one row per cycle from reset.
    for (int i = 0; i < 21; i++) begin
      int c;
      c = i - 2;
      vt[i] = '{default: '0};
      vt[i].rdy = 1'b1;
      if (i < 2) begin
        vt[i].rst = 1'b1;
      end else begin
        vt[i].en     = 1'b1;
        vt[i].rd_en  = (c <= 15);
        vt[i].tvalid = (c >= 2 && c <= 17);
        vt[i].tdata  = (c >= 2 && c <= 17) ? 8'(c - 2) : 8'h00;
        vt[i].tlast  = (c == 17);
        vt[i].tuser  = (c == 2);
        vt[i].done   = (c == 18);
        vt[i].busy   = (c >= 1 && c <= 17);
      end
    end

    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) begin
      if (i == 2) load(0, 16);
      step(vt[i].rst, vt[i].en, vt[i].rdy);
      chk("v_rd_en", 32'(fifo_rd_en), 32'(vt[i].rd_en));
      chk("v_tvalid", 32'(axis_tvalid), 32'(vt[i].tvalid));
      if (i < 4 || vt[i].tvalid) chk("v_tdata", 32'(axis_tdata), 32'(vt[i].tdata));
      chk("v_tlast", 32'(axis_tlast), 32'(vt[i].tlast));
      chk("v_tuser", 32'(axis_tuser), 32'(vt[i].tuser));
      chk("v_pkt_done", 32'(pkt_done), 32'(vt[i].done));
      chk("v_busy", 32'(busy), 32'(vt[i].busy));
      chk("v_ovf", 32'(ovf_err), 32'd0);
    end

    // 40 words with tready toggling every clock.
    do_reset();
    load(8'h40, 40);
    run_until(40, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("toggle_tlast_count", 32'(n_tlast), 32'd2);
    chk("toggle_tuser_count", 32'(n_tuser), 32'd3);
    chk("toggle_leftover", 32'(expq.size()), 32'd0);
    chk("toggle_ovf", 32'(ovf_err), 32'd0);

    // tready held low for 10 clocks mid-packet.
    do_reset();
    load(8'h80, 24);
    run_until(5, 1'b0);
    n_rd = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      n_rd += int'(fifo_rd_en);
      if (i >= 2) chk("hold_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    chk("hold_reads_max2", 32'(n_rd <= 2), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("resume_rate", 32'(axis_tvalid), 32'd1);
    end
    run_until(24, 1'b0);

    // FIFO runs dry after 5 beats, refilled 20 clocks later.
    do_reset();
    load(8'hA0, 5);
    for (int i = 0; i < 27; i++) step(1'b0, 1'b1, 1'b1);
    chk("gap_beats", 32'(n_beats), 32'd5);
    chk("gap_no_tlast", 32'(n_tlast), 32'd0);
    chk("gap_tvalid", 32'(axis_tvalid), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    load(8'hA5, 11);
    run_until(16, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("gap_tlast_once", 32'(n_tlast), 32'd1);

    // Reset with both buffer entries full at beat 7.
    do_reset();
    load(8'hC0, 20);
    run_until(7, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(axis_tvalid), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_tvalid", 32'(axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(axis_tdata), 32'd0);
    chk("rst_flags", 32'({axis_tlast, axis_tuser}), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    load(8'hD0, 4);
    run_until(4, 1'b0);
    chk("rst_sop_count", 32'(n_tuser), 32'd1);

    // Injected read data while the buffer is full and stalled.
    do_reset();
    load(8'hE0, 10);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    inj = 1;
    step(1'b0, 1'b1, 1'b0);
    inj = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("ovf_sticky", 32'(ovf_err), 32'd1);
      chk("ovf_head_kept", 32'(axis_tdata), 32'h0E0);
    end
    run_until(10, 1'b0);
    chk("ovf_after_drain", 32'(ovf_err), 32'd1);
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_axis_packetizer.md
Name: fifo_axis_packetizer

Overview:
- Downstream read stage of the synchronous FIFO. Drains FIFO words and emits them as AXI4-Stream beats grouped into fixed-length packets (tlast every PACKET_LEN beats).
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer and credit-based read issue.
- Sustains 1 beat/clk under continuous tready, never loses data under backpressure.

Parameters:
DATA_WIDTH, 8, FIFO word and tdata width
PACKET_LEN, 16, beats per packet, >= 1; counter width = $clog2(PACKET_LEN)+1 (localparam)

Ports:
i_clk  in  1  clock
i_s_rst  in  1  synchronous reset, active-high; shared with upstream FIFO
i_en  in  1  enable read issue
o_fifo_rd_en  out  1  FIFO read strobe
i_fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid with i_fifo_rd_valid
i_fifo_rd_valid  in  1  FIFO read data valid, 1 clk after accepted rd_en
i_fifo_empty  in  1  FIFO empty flag
o_axis_tdata  out  DATA_WIDTH  stream data
o_axis_tvalid  out  1  stream valid
i_axis_tready  in  1  stream ready
o_axis_tlast  out  1  last beat of packet
o_axis_tuser  out  1  first beat of packet (SOP)
o_pkt_done  out  1  1-clk pulse when tlast beat accepted
o_busy  out  1  occ != 0 or inflight or beat_cnt != 0
o_ovf_err  out  1  sticky, buffer overflow detected

Behaviour:
- One clock: one clock domain, i_clk. Reset: synchronous, active-high, i_s_rst.
- Reset state: occ=0, inflight=0, beat_cnt=0, both buffer entries cleared, o_ovf_err=0.
- Outputs during/after reset: tvalid=0, tlast=0, tuser=0, tdata=0, pkt_done=0, busy=0, rd_en=0.
- pop = o_axis_tvalid & i_axis_tready.
- Read issue (combinational): o_fifo_rd_en = i_en & !i_fifo_empty & !i_s_rst & ((occ + inflight - pop) < 2). The tready-to-rd_en combinational path is intentional.
- inflight <= o_fifo_rd_en, registered.
- Buffer: 2-entry FIFO of registers; head drives tdata. occ_next = occ + i_fifo_rd_valid - pop.
- Simultaneous push and pop at occ=1: head is replaced by the incoming word; occ stays 1.
- o_axis_tvalid = (occ != 0). tdata/tvalid are fully registered (no path from i_fifo_rd_data to outputs).
- Latency with an empty pipeline: rd_en in cycle N, rd_valid/data in N+1, tvalid in N+2.
- Steady state with tready=1: occ=1, inflight=1, one beat per clk.
- tdata/tvalid/tlast/tuser hold stable while tvalid & !tready (AXI rule).
- beat_cnt increments on pop; wraps PACKET_LEN-1 -> 0.
- tlast = tvalid & (beat_cnt == PACKET_LEN-1). tuser = tvalid & (beat_cnt == 0). PACKET_LEN=1: every beat has tlast=tuser=1.
- o_pkt_done <= pop & tlast.
- i_en low: no new reads. In-flight and buffered words still drain. beat_cnt is kept, so the packet resumes mid-count when re-enabled.
- FIFO empty mid-packet: tvalid drops; no tlast inserted; packet continues when data returns.
- Overflow: i_fifo_rd_valid with occ==2 and !pop sets o_ovf_err (sticky until reset). The word is dropped. Unreachable if upstream obeys the 1-clk latency.
- Reset mid-packet: buffered and in-flight words are discarded; the next beat after reset carries tuser=1.
- i_fifo_rd_valid is ignored while i_s_rst=1.

Test Plan:
- Reset, then FIFO preloaded 0x00..0x0F, PACKET_LEN=16, tready=1, i_en=1 -> rd_en from cycle 0; 16 consecutive beats 0x00..0x0F from cycle 2; tuser on 0x00, tlast and pkt_done on 0x0F; busy=0 after.
- 40 words, PACKET_LEN=16, tready toggled 1/0 every clk -> no loss/duplication; tlast on beats 15 and 31; tuser on 0, 16, 32; occ never >2; o_ovf_err=0.
- tready held 0 for 10 clk mid-packet -> at most 2 reads issued; tdata/tlast/tuser stable; rd_en=0 until tready returns; then 1 beat/clk.
- FIFO empties after 5 words of a 16-beat packet, refilled 20 clk later -> beats 5..15 continue; tlast on beat 15 only; no tlast at the gap.
- i_s_rst pulsed with occ=2 at beat_cnt=7 -> all outputs 0 the next clk; next emitted beat has tuser=1; beat_cnt restarts at 0.
- Injected rd_valid with occ=2, tready=0 -> o_ovf_err=1 and stays 1 until reset; buffered data unchanged.
